// File: rtl/pipe_reg_skid_if.sv
// -----------------------------------------------------------------------------
// pipe_reg_skid_if
// Valid/ready handshake bundle carrying one ID->EX entry (opcode, A, B).
//   master : drives valid/opcode/a/b, samples ready   (producer side)
//   slave  : samples valid/opcode/a/b, drives ready   (consumer side)
// Parameters: OPW opcode width, DW operand width.
// -----------------------------------------------------------------------------
interface pipe_reg_skid_if #(
  parameter int OPW = 4,
  parameter int DW  = 8
);
  logic           valid;
  logic           ready;
  logic [OPW-1:0] opcode;
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;

  modport master (output valid, output opcode, output a, output b, input ready);
  modport slave  (input valid, input opcode, input a, input b, output ready);
endinterface

// File: rtl/pipe_reg_skid.sv
// -----------------------------------------------------------------------------
// pipe_reg_skid
// ID->EX pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. Full throughput under back-pressure, in-order and lossless; in_ready
// is a flop output with no combinational path from out_ready.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   flush      in   synchronous kill of all held entries (beats any accept)
//   in_if      slave  upstream entry  (valid/opcode/a/b in, ready out)
//   out_if     master entry to EX     (valid/opcode/a/b out, ready in)
//   stall_cnt  out  saturating back-pressure cycle count
//                   (only when PIPE_STALL_CNT_EN is defined)
//
// Build option: define PIPE_STALL_CNT_EN to add the CW parameter, the
// stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module pipe_reg_skid #(
  parameter int OPW = 4,
  parameter int DW  = 8
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int CW  = 16
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  pipe_reg_skid_if.slave     in_if,
  pipe_reg_skid_if.master    out_if
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CW-1:0]      stall_cnt
`endif
);

  // Encoding is {skid_v, main_v} so the valids fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t state, state_n;

  logic           main_v, skid_v;
  logic           in_acc, out_acc;
  logic           load_main_in;   // main <= upstream entry
  logic           load_skid;      // skid <= upstream entry
  logic           move_skid;      // main <= skid

  logic [OPW-1:0] main_op, skid_op;
  logic [DW-1:0]  main_a, main_b, skid_a, skid_b;

  assign main_v  = state[0];
  assign skid_v  = state[1];
  assign in_acc  = in_if.valid & ~skid_v;
  assign out_acc = main_v & out_if.ready;

  // NOTE: state and data are updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n      = state;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_acc) begin
            state_n      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_acc && !out_acc) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end else if (in_acc && out_acc) begin
            load_main_in = 1'b1;
          end else if (out_acc) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (out_acc) begin
            state_n   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset as well so out_* read 0 after reset;
  // they are few enough that the reset cost does not matter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_op <= '0;
      main_a  <= '0;
      main_b  <= '0;
      skid_op <= '0;
      skid_a  <= '0;
      skid_b  <= '0;
    end else begin
      if (load_main_in) begin
        main_op <= in_if.opcode;
        main_a  <= in_if.a;
        main_b  <= in_if.b;
      end else if (move_skid) begin
        main_op <= skid_op;
        main_a  <= skid_a;
        main_b  <= skid_b;
      end
      if (load_skid) begin
        skid_op <= in_if.opcode;
        skid_a  <= in_if.a;
        skid_b  <= in_if.b;
      end
    end
  end

  assign out_if.valid  = main_v;
  assign out_if.opcode = main_op;
  assign out_if.a      = main_a;
  assign out_if.b      = main_b;
  assign in_if.ready   = ~skid_v;

`ifdef PIPE_STALL_CNT_EN
  // Counts cycles where EX holds off a valid entry; survives flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (main_v && !out_if.ready && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
